// File: rtl/cell_switch_fabric.sv
// N-port cell switch: Avalon-MM writes fill per-input show-ahead FIFOs, and a per-output
// round-robin arbiter moves each head cell to the output named by its destination field.
module cell_switch_fabric #(
  parameter int N_PORTS    = 3,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 3,
  parameter int DEST_W     = $clog2(N_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        chipselect,
  input  logic                        write,
  input  logic                        read,
  input  logic [ADDR_W-1:0]           address,
  input  logic [DATA_W-1:0]           writedata,
  output logic [DATA_W-1:0]           readdata,
  output logic [N_PORTS-1:0]          out_valid,
  output logic [N_PORTS*DATA_W-1:0]   out_data,
  input  logic [N_PORTS-1:0]          out_ready
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [DATA_W-1:0] mem [N_PORTS][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [N_PORTS];
  logic [PTR_W-1:0]  rd_ptr [N_PORTS];
  logic [CNT_W-1:0]  count  [N_PORTS];
  logic [IDX_W-1:0]  rr_ptr [N_PORTS];
  logic [DATA_W-1:0] drop_cnt;

  logic [DATA_W-1:0] head      [N_PORTS];
  logic [DEST_W-1:0] head_dest [N_PORTS];
  logic [N_PORTS-1:0] nonempty, full, bad_head, push, pop, grant_any;
  logic [N_PORTS-1:0] req   [N_PORTS];
  logic [IDX_W-1:0]   grant [N_PORTS];

  logic              wr_en, rd_en, wr_fifo, push_drop, clear;
  logic [31:0]       addr_u;
  logic [IDX_W-1:0]  fifo_sel;
  logic [3:0]        drop_inc;
  logic [DATA_W+3:0] drop_sum;
  logic [DATA_W-1:0] read_val;

  assign wr_en    = chipselect && write;
  assign rd_en    = chipselect && read;
  assign addr_u   = 32'(address);
  assign fifo_sel = IDX_W'(addr_u - 32'd1);
  assign wr_fifo  = wr_en && (addr_u >= 32'd1) && (addr_u <= 32'(N_PORTS));
  assign clear    = wr_en && (addr_u == 32'd0);

  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      head[i]      = mem[i][rd_ptr[i]];
      head_dest[i] = head[i][DATA_W-1 -: DEST_W];
      nonempty[i]  = (count[i] != '0);
      full[i]      = (count[i] == CNT_W'(FIFO_DEPTH));
      bad_head[i]  = nonempty[i] && (32'(head_dest[i]) >= 32'(N_PORTS));
    end
  end

  // Full is taken from the registered count, so a same-cycle pop never makes room for a push.
  always_comb begin
    push      = '0;
    push_drop = 1'b0;
    if (wr_fifo) begin
      if (full[fifo_sel]) push_drop = 1'b1;
      else                push[fifo_sel] = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned o = 0; o < N_PORTS; o++) begin
      req[o]       = '0;
      grant[o]     = '0;
      grant_any[o] = 1'b0;
      for (int unsigned i = 0; i < N_PORTS; i++)
        req[o][i] = nonempty[i] && (32'(head_dest[i]) == o);
      if (!out_valid[o] || out_ready[o]) begin
        for (int unsigned k = 0; k < N_PORTS; k++) begin
          if (!grant_any[o] && req[o][IDX_W'((32'(rr_ptr[o]) + k) % N_PORTS)]) begin
            grant_any[o] = 1'b1;
            grant[o]     = IDX_W'((32'(rr_ptr[o]) + k) % N_PORTS);
          end
        end
      end
    end
  end

  // Each head carries a single destination, so at most one output can grant a given FIFO.
  always_comb begin
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      pop[i] = bad_head[i];
      for (int unsigned o = 0; o < N_PORTS; o++)
        if (grant_any[o] && (32'(grant[o]) == i)) pop[i] = 1'b1;
    end
  end

  always_comb begin
    drop_inc = 4'(push_drop);
    for (int unsigned i = 0; i < N_PORTS; i++)
      drop_inc = drop_inc + 4'(bad_head[i]);
    drop_sum = {4'b0000, drop_cnt} + (DATA_W+4)'(drop_inc);
  end

  always_comb begin
    read_val = '0;
    if (addr_u == 32'd0)
      read_val = DATA_W'(full);
    else if (addr_u <= 32'(N_PORTS))
      read_val = DATA_W'(count[fifo_sel]);
    else if (addr_u == 32'(N_PORTS + 1))
      read_val = drop_cnt;
  end

  always_ff @(posedge clk) begin
    if (wr_fifo && !full[fifo_sel])
      mem[fifo_sel][wr_ptr[fifo_sel]] <= writedata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_PORTS; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= '0;
      out_data  <= '0;
      for (int unsigned o = 0; o < N_PORTS; o++) rr_ptr[o] <= '0;
    end else begin
      for (int unsigned o = 0; o < N_PORTS; o++) begin
        if (!out_valid[o] || out_ready[o]) begin
          out_valid[o] <= grant_any[o];
          if (grant_any[o]) begin
            out_data[o*DATA_W +: DATA_W] <= head[grant[o]];
            rr_ptr[o] <= (32'(grant[o]) == 32'(N_PORTS - 1)) ? '0 : grant[o] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
      readdata <= '0;
    end else begin
      if (clear)
        drop_cnt <= '0;
      else if (drop_sum > (DATA_W+4)'({DATA_W{1'b1}}))
        drop_cnt <= '1;
      else
        drop_cnt <= drop_sum[DATA_W-1:0];
      if (rd_en) readdata <= read_val;
    end
  end

endmodule

// File: tb/tb_cell_switch_fabric.sv
// Self-checking bench for cell_switch_fabric: fixed vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_cell_switch_fabric;

  localparam int N = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [2:0]  address = '0;
  logic [7:0]  writedata = '0;
  logic [7:0]  readdata;
  logic [2:0]  out_valid;
  logic [23:0] out_data;
  logic [2:0]  out_ready = '0;

  int n_cmp = 0;
  int n_fail = 0;

  cell_switch_fabric #(.N_PORTS(3), .DATA_W(8), .FIFO_DEPTH(4), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [7:0] mq [N][$];
  logic [2:0] m_valid;
  logic [7:0] m_data [N];
  int         m_ptr [N];
  int         m_drop;
  logic [7:0] m_rdata;

  function automatic int dest_of(input logic [7:0] c);
    return int'(c[7:6]);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_data[i] = '0;
      m_ptr[i] = 0;
    end
    m_valid = '0;
    m_drop = 0;
    m_rdata = '0;
  endfunction

  function automatic void model_step();
    int drops = 0;
    bit popq [N];
    int a = int'(address);
    bit do_push = 0;
    for (int i = 0; i < N; i++) popq[i] = 0;
    if (chipselect && read) begin
      if (a == 0) begin
        m_rdata = '0;
        for (int i = 0; i < N; i++) m_rdata[i] = (mq[i].size() == DEPTH);
      end else if (a <= N) m_rdata = 8'(mq[a-1].size());
      else if (a == N + 1) m_rdata = 8'(m_drop);
      else m_rdata = '0;
    end
    for (int i = 0; i < N; i++)
      if (mq[i].size() > 0 && dest_of(mq[i][0]) >= N) begin
        popq[i] = 1;
        drops++;
      end
    for (int o = 0; o < N; o++) begin
      if (!m_valid[o] || out_ready[o]) begin
        bit found = 0;
        for (int k = 0; k < N; k++) begin
          int i = (m_ptr[o] + k) % N;
          if (!found && mq[i].size() > 0 && dest_of(mq[i][0]) == o) begin
            found = 1;
            m_data[o] = mq[i][0];
            popq[i] = 1;
            m_ptr[o] = (i + 1) % N;
          end
        end
        m_valid[o] = found;
      end
    end
    if (chipselect && write && a >= 1 && a <= N) begin
      if (mq[a-1].size() == DEPTH) drops++;
      else do_push = 1;
    end
    for (int i = 0; i < N; i++) if (popq[i]) void'(mq[i].pop_front());
    if (do_push) mq[a-1].push_back(writedata);
    if (chipselect && write && a == 0) m_drop = 0;
    else m_drop = (m_drop + drops > 255) ? 255 : m_drop + drops;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("out_data", 32'(out_data), 32'({m_data[2], m_data[1], m_data[0]}));
    check("readdata", 32'(readdata), 32'(m_rdata));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic idle();
    chipselect = 0; write = 0; read = 0;
  endtask

  task automatic wr_cell(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1; write = 1; read = 0; address = a; writedata = d;
    cycle();
    idle();
  endtask

  task automatic rd_reg(input logic [2:0] a);
    chipselect = 1; write = 0; read = 1; address = a;
    cycle();
    idle();
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_reset();
    check("reset_valid", 32'(out_valid), 32'(0));
    check("reset_data", 32'(out_data), 32'(0));
    check("reset_rdata", 32'(readdata), 32'(0));
    @(posedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  typedef struct {
    logic       wr;
    logic       rd;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [2:0] exp_valid;
    logic [23:0] exp_data;
    logic [7:0] exp_rdata;
  } vec_t;

  vec_t tbl [12];
  logic [7:0] rr_seq [5];

  initial begin
    tbl[0]  = '{1'b1, 1'b0, 3'd1, 8'h05, 3'b000, 24'h000000, 8'h00};
    tbl[1]  = '{1'b0, 1'b1, 3'd1, 8'h00, 3'b001, 24'h000005, 8'h01};
    tbl[2]  = '{1'b0, 1'b1, 3'd1, 8'h00, 3'b000, 24'h000005, 8'h00};
    tbl[3]  = '{1'b1, 1'b0, 3'd2, 8'h83, 3'b000, 24'h000005, 8'h00};
    tbl[4]  = '{1'b1, 1'b0, 3'd3, 8'h47, 3'b100, 24'h830005, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 3'd0, 8'h00, 3'b010, 24'h834705, 8'h00};
    tbl[6]  = '{1'b1, 1'b0, 3'd1, 8'hC0, 3'b000, 24'h834705, 8'h00};
    tbl[7]  = '{1'b0, 1'b1, 3'd4, 8'h00, 3'b000, 24'h834705, 8'h00};
    tbl[8]  = '{1'b0, 1'b1, 3'd4, 8'h00, 3'b000, 24'h834705, 8'h01};
    tbl[9]  = '{1'b0, 1'b1, 3'd5, 8'h00, 3'b000, 24'h834705, 8'h00};
    tbl[10] = '{1'b1, 1'b0, 3'd0, 8'hAA, 3'b000, 24'h834705, 8'h00};
    tbl[11] = '{1'b0, 1'b1, 3'd4, 8'h00, 3'b000, 24'h834705, 8'h00};
    rr_seq = '{8'h50, 8'h60, 8'h41, 8'h51, 8'h61};

    do_reset();

    out_ready = 3'b111;
    for (int v = 0; v < 12; v++) begin
      chipselect = tbl[v].wr | tbl[v].rd;
      write = tbl[v].wr; read = tbl[v].rd;
      address = tbl[v].addr; writedata = tbl[v].wdata;
      cycle();
      check($sformatf("tbl%0d_valid", v), 32'(out_valid), 32'(tbl[v].exp_valid));
      check($sformatf("tbl%0d_data", v), 32'(out_data), 32'(tbl[v].exp_data));
      check($sformatf("tbl%0d_rdata", v), 32'(readdata), 32'(tbl[v].exp_rdata));
    end
    idle();

    // Fill FIFO 1 past capacity while output 1 is stalled.
    out_ready = 3'b000;
    for (int k = 0; k < 6; k++) wr_cell(3'd2, 8'h41 + 8'(k));
    rd_reg(3'd0); check("t2_full", 32'(readdata), 32'h02);
    rd_reg(3'd4); check("t2_drop", 32'(readdata), 32'h01);
    rd_reg(3'd2); check("t2_occ", 32'(readdata), 32'h04);
    check("t2_out1", 32'(out_data[15:8]), 32'h41);

    for (int k = 0; k < 5; k++) begin
      cycle();
      check("t4_hold", 32'(out_data[15:8]), 32'h41);
    end
    out_ready = 3'b010;
    cycle();
    check("t4_release", 32'(out_data[15:8]), 32'h42);
    for (int k = 0; k < 6; k++) cycle();
    check("t4_drained", 32'(out_valid), 32'h0);

    // Bad-destination cell, then a clear landing on the edge that discards it.
    wr_cell(3'd0, 8'h00);
    wr_cell(3'd1, 8'hC0);
    cycle();
    rd_reg(3'd4); check("t5_drop", 32'(readdata), 32'h01);
    wr_cell(3'd1, 8'hC1);
    wr_cell(3'd0, 8'h00);
    rd_reg(3'd4); check("t5_clear_wins", 32'(readdata), 32'h00);

    out_ready = 3'b000;
    for (int k = 0; k < 3; k++) begin
      wr_cell(3'd1, 8'h01 + 8'(k));
      wr_cell(3'd2, 8'h42 + 8'(k));
      wr_cell(3'd3, 8'h83 + 8'(k));
    end
    check("t6_pre_valid", 32'(out_valid), 32'h7);
    #3;
    do_reset();
    for (int a = 0; a <= 4; a++) begin
      rd_reg(3'(a));
      check($sformatf("t6_read%0d", a), 32'(readdata), 32'h0);
    end

    // Round robin on output 1 from a fresh pointer.
    out_ready = 3'b000;
    wr_cell(3'd1, 8'h40); wr_cell(3'd2, 8'h50); wr_cell(3'd3, 8'h60);
    wr_cell(3'd1, 8'h41); wr_cell(3'd2, 8'h51); wr_cell(3'd3, 8'h61);
    check("t3_first", 32'(out_data[15:8]), 32'h40);
    out_ready = 3'b010;
    for (int k = 0; k < 5; k++) begin
      cycle();
      check($sformatf("t3_grant%0d", k), 32'(out_data[15:8]), 32'(rr_seq[k]));
    end
    cycle();
    check("t3_empty", 32'(out_valid), 32'h0);

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        #2;
        do_reset();
      end
      chipselect = ($urandom_range(0, 3) != 0);
      write = $urandom_range(0, 1);
      read = $urandom_range(0, 1);
      address = 3'($urandom_range(0, 7));
      writedata = 8'($urandom);
      out_ready = 3'($urandom);
      cycle();
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
